// File: rtl/controle_escrita.sv
// Write-back controller: queues ULA/MEM write-back requests in an in-order FIFO and drives
// the register bank write port (sinal/entrada3/dado) with one write per cycle.
module controle_escrita #(
   parameter int PROFUNDIDADE = 4,
   parameter int LARGURA      = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                mem_valid,
   input  logic [3:0]                          mem_reg,
   input  logic [LARGURA-1:0]                  mem_dado,
   output logic                                mem_ready,
   input  logic                                ula_valid,
   input  logic [3:0]                          ula_reg,
   input  logic [LARGURA-1:0]                  ula_dado,
   output logic                                ula_ready,
   output logic                                sinal,
   output logic [3:0]                          entrada3,
   output logic [LARGURA-1:0]                  dado,
   output logic [15:0]                         pendente,
   output logic [$clog2(PROFUNDIDADE+1)-1:0]   ocupacao
);
   localparam int CW = $clog2(PROFUNDIDADE + 1);
   localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
   localparam logic [CW-1:0] LIM_UM   = CW'(PROFUNDIDADE - 1);
   localparam logic [CW-1:0] LIM_DOIS = CW'(PROFUNDIDADE - 2);
   localparam logic [PW-1:0] ULTIMO   = PW'(PROFUNDIDADE - 1);

   logic [3:0]         fila_reg_q  [PROFUNDIDADE];
   logic [LARGURA-1:0] fila_dado_q [PROFUNDIDADE];
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, ula_slot_s;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sinal_q, sinal_d;
   logic [3:0]         entrada3_q, entrada3_d;
   logic [LARGURA-1:0] dado_q, dado_d;
   logic               push_mem_s, push_ula_s, pop_s;

   // Modulo-PROFUNDIDADE increment so non-power-of-2 depths wrap correctly.
   function automatic logic [PW-1:0] avanca(input logic [PW-1:0] ptr);
      if (ptr == ULTIMO) begin
         return {PW{1'b0}};
      end else begin
         return ptr + PW'(1'b1);
      end
   endfunction

   assign mem_ready = (cnt_q <= LIM_UM);
   assign ula_ready = mem_valid ? (cnt_q <= LIM_DOIS) : (cnt_q <= LIM_UM);

   always_comb begin
      push_mem_s = mem_valid & mem_ready;
      push_ula_s = ula_valid & ula_ready;
      pop_s      = (cnt_q != {CW{1'b0}});
      // MEM is the older instruction, so it takes the first free slot.
      ula_slot_s = push_mem_s ? avanca(wr_ptr_q) : wr_ptr_q;
      wr_ptr_d   = push_ula_s ? avanca(ula_slot_s) : ula_slot_s;
      cnt_d      = cnt_q + CW'(push_mem_s) + CW'(push_ula_s) - CW'(pop_s);
      if (pop_s) begin
         rd_ptr_d   = avanca(rd_ptr_q);
         sinal_d    = 1'b1;
         entrada3_d = fila_reg_q[rd_ptr_q];
         dado_d     = fila_dado_q[rd_ptr_q];
      end else begin
         rd_ptr_d   = rd_ptr_q;
         sinal_d    = 1'b0;
         entrada3_d = entrada3_q;
         dado_d     = dado_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q   <= {PW{1'b0}};
         wr_ptr_q   <= {PW{1'b0}};
         cnt_q      <= {CW{1'b0}};
         sinal_q    <= 1'b0;
         entrada3_q <= 4'h0;
         dado_q     <= {LARGURA{1'b0}};
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
         sinal_q    <= sinal_d;
         entrada3_q <= entrada3_d;
         dado_q     <= dado_d;
      end
   end

   // Payload storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push_mem_s) begin
         fila_reg_q[wr_ptr_q]  <= mem_reg;
         fila_dado_q[wr_ptr_q] <= mem_dado;
      end
      if (push_ula_s) begin
         fila_reg_q[ula_slot_s]  <= ula_reg;
         fila_dado_q[ula_slot_s] <= ula_dado;
      end
   end

   always_comb begin
      pendente = 16'h0000;
      for (int s = 0; s < PROFUNDIDADE; s++) begin
         if (((s + PROFUNDIDADE - int'(rd_ptr_q)) % PROFUNDIDADE) < int'(cnt_q)) begin
            pendente = pendente | (16'h0001 << fila_reg_q[s]);
         end else begin
            pendente = pendente;
         end
      end
      if (sinal_q) begin
         pendente = pendente | (16'h0001 << entrada3_q);
      end else begin
         pendente = pendente;
      end
   end

   assign sinal    = sinal_q;
   assign entrada3 = entrada3_q;
   assign dado     = dado_q;
   assign ocupacao = cnt_q;
endmodule

// File: tb/tb_controle_escrita.sv
// Bench for controle_escrita: depth-4 and depth-3 instances checked every cycle against a
// queue-based reference model, plus directed checks of the documented scenarios.
module tb_controle_escrita;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, cur;
   logic        mv, uv;
   logic [3:0]  mr, ur;
   logic [15:0] md, ud;

   logic        mrdy4, urdy4, sn4, mrdy3, urdy3, sn3;
   logic [3:0]  e34, e33;
   logic [15:0] dd4, pd4, dd3, pd3;
   logic [2:0]  oc4;
   logic [1:0]  oc3;

   controle_escrita #(.PROFUNDIDADE(4), .LARGURA(16)) u_d4 (
      .clk(clk), .reset(reset),
      .mem_valid(mv & ~cur), .mem_reg(mr), .mem_dado(md), .mem_ready(mrdy4),
      .ula_valid(uv & ~cur), .ula_reg(ur), .ula_dado(ud), .ula_ready(urdy4),
      .sinal(sn4), .entrada3(e34), .dado(dd4), .pendente(pd4), .ocupacao(oc4));

   controle_escrita #(.PROFUNDIDADE(3), .LARGURA(16)) u_d3 (
      .clk(clk), .reset(reset),
      .mem_valid(mv & cur), .mem_reg(mr), .mem_dado(md), .mem_ready(mrdy3),
      .ula_valid(uv & cur), .ula_reg(ur), .ula_dado(ud), .ula_ready(urdy3),
      .sinal(sn3), .entrada3(e33), .dado(dd3), .pendente(pd3), .ocupacao(oc3));

   logic        o_mrdy, o_urdy, o_sn;
   logic [3:0]  o_e3;
   logic [15:0] o_dd, o_pd;
   logic [2:0]  o_occ;
   assign o_mrdy = cur ? mrdy3 : mrdy4;
   assign o_urdy = cur ? urdy3 : urdy4;
   assign o_sn   = cur ? sn3 : sn4;
   assign o_e3   = cur ? e33 : e34;
   assign o_dd   = cur ? dd3 : dd4;
   assign o_pd   = cur ? pd3 : pd4;
   assign o_occ  = cur ? {1'b0, oc3} : oc4;

   // Reference model: queue of accepted {reg,data} plus the write currently on the port.
   logic [19:0] fila[$];
   logic        port_v, acc_m, acc_u;
   logic [3:0]  port_r;
   logic [15:0] port_d;
   logic [15:0] bank [16];
   int          checks, failures, pushes, writes;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      int          p, cnt;
      logic [15:0] pend_exp;
      logic        s_v;
      logic [3:0]  s_r;
      logic [15:0] s_d;
      p = cur ? 3 : 4;
      #1;
      cnt = fila.size();
      pend_exp = port_v ? (16'h0001 << port_r) : 16'h0000;
      foreach (fila[i]) pend_exp = pend_exp | (16'h0001 << fila[i][19:16]);
      chk("sinal", 32'(o_sn), 32'(port_v));
      chk("entrada3", 32'(o_e3), 32'(port_r));
      chk("dado", 32'(o_dd), 32'(port_d));
      chk("ocupacao", 32'(o_occ), 32'(cnt));
      chk("pendente", 32'(o_pd), 32'(pend_exp));
      chk("mem_ready", 32'(o_mrdy), 32'(cnt <= p - 1));
      chk("ula_ready", 32'(o_urdy), 32'(mv ? (cnt <= p - 2) : (cnt <= p - 1)));
      chk("ocupacao_limit", 32'(int'(o_occ) <= p), 32'(1));
      acc_m = !reset && mv && (cnt <= p - 1);
      acc_u = !reset && uv && (mv ? (cnt <= p - 2) : (cnt <= p - 1));
      s_v = o_sn; s_r = o_e3; s_d = o_dd;
      @(posedge clk);
      if (s_v) bank[s_r] = s_d;
      if (reset) begin
         fila.delete();
         port_v = 1'b0; port_r = 4'h0; port_d = 16'h0000;
      end else begin
         if (fila.size() > 0) begin
            {port_r, port_d} = fila.pop_front();
            port_v = 1'b1;
            writes++;
         end else begin
            port_v = 1'b0;
         end
         if (acc_m) begin fila.push_back({mr, md}); pushes++; end
         if (acc_u) begin fila.push_back({ur, ud}); pushes++; end
      end
      #1;
   endtask

   task automatic drain();
      mv = 1'b0; uv = 1'b0;
      for (int c = 0; c < 12 && (fila.size() > 0 || port_v); c++) tick();
      tick();
      chk("drain_done", 32'(fila.size()), 32'(0));
   endtask

   initial begin
      checks = 0; failures = 0; pushes = 0; writes = 0;
      cur = 1'b0; reset = 1'b1;
      mv = 1'b0; uv = 1'b0; mr = 4'h0; ur = 4'h0; md = 16'h0000; ud = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      fila.delete(); port_v = 1'b0; port_r = 4'h0; port_d = 16'h0000;

      // T1: idle after reset
      tick();
      chk("t1_sinal", 32'(o_sn), 32'(0));
      chk("t1_pendente", 32'(o_pd), 32'(0));
      chk("t1_mem_ready", 32'(o_mrdy), 32'(1));
      chk("t1_ula_ready", 32'(o_urdy), 32'(1));
      chk("t1_ocupacao", 32'(o_occ), 32'(0));

      // T2: single ULA write to R5
      uv = 1'b1; ur = 4'd5; ud = 16'h1234;
      tick();
      uv = 1'b0;
      tick();
      chk("t2_sinal", 32'(o_sn), 32'(1));
      chk("t2_entrada3", 32'(o_e3), 32'(5));
      chk("t2_dado", 32'(o_dd), 32'(16'h1234));
      chk("t2_pendente", 32'(o_pd), 32'(16'h0020));
      tick();
      chk("t2_bank_r5", 32'(bank[5]), 32'(16'h1234));
      chk("t2_pendente_clear", 32'(o_pd), 32'(0));

      // T3: MEM and ULA to R2 in the same cycle
      mv = 1'b1; mr = 4'd2; md = 16'hAAAA;
      uv = 1'b1; ur = 4'd2; ud = 16'h5555;
      tick();
      mv = 1'b0; uv = 1'b0;
      tick();
      chk("t3_first_dado", 32'(o_dd), 32'(16'hAAAA));
      chk("t3_first_pend", 32'(o_pd), 32'(16'h0004));
      tick();
      chk("t3_second_dado", 32'(o_dd), 32'(16'h5555));
      chk("t3_second_pend", 32'(o_pd), 32'(16'h0004));
      tick();
      chk("t3_bank_r2", 32'(bank[2]), 32'(16'h5555));
      chk("t3_pend_clear", 32'(o_pd), 32'(0));

      // T4: both producers valid every cycle
      writes = 0;
      mv = 1'b1; mr = 4'($urandom_range(0, 15)); md = 16'($urandom);
      uv = 1'b1; ur = 4'($urandom_range(0, 15)); ud = 16'($urandom);
      for (int c = 0; c < 40 && writes < 12; c++) begin
         tick();
         if (acc_m) begin mr = 4'($urandom_range(0, 15)); md = 16'($urandom); end
         if (acc_u) begin ur = 4'($urandom_range(0, 15)); ud = 16'($urandom); end
      end
      chk("t4_writes_reached", 32'(writes >= 12), 32'(1));
      drain();

      // T5: reset with entries queued and a write on the port
      mv = 1'b1; mr = 4'd7; md = 16'hBEEF;
      uv = 1'b1; ur = 4'd9; ud = 16'hCAFE;
      tick();
      md = 16'hD00D; ud = 16'hF00D;
      tick();
      chk("t5_pre_occ", 32'(o_occ), 32'(3));
      chk("t5_pre_sinal", 32'(o_sn), 32'(1));
      reset = 1'b1;
      tick();
      reset = 1'b0; mv = 1'b0; uv = 1'b0;
      chk("t5_sinal", 32'(o_sn), 32'(0));
      chk("t5_ocupacao", 32'(o_occ), 32'(0));
      chk("t5_pendente", 32'(o_pd), 32'(0));
      repeat (3) tick();

      // T6: depth-3 instance, randomized valids, pointer wrap
      cur = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0;
      pushes = 0;
      for (int c = 0; c < 400 && pushes < 60; c++) begin
         if (!mv && $urandom_range(0, 3) != 0) begin
            mv = 1'b1; mr = 4'($urandom_range(0, 15)); md = 16'($urandom);
         end
         if (!uv && $urandom_range(0, 3) != 0) begin
            uv = 1'b1; ur = 4'($urandom_range(0, 15)); ud = 16'($urandom);
         end
         tick();
         if (acc_m) mv = 1'b0;
         if (acc_u) uv = 1'b0;
      end
      chk("t6_pushes_reached", 32'(pushes >= 60), 32'(1));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
